kiwi_waypoint_logger: RTL
=========================

Name: kiwi_waypoint_logger

Overview:
- Monitor stage between a Kiwi-generated DUT and the simulation/FPGA test wrapper.
- Watches the DUT's ASCII waypoint bus, PC export and abend syndrome; keeps a run cycle counter; timestamps every waypoint change.
- Queues change records in a small FIFO and drains them over a valid/ready stream, which a $display shim or UART consumes.
- Latches completion (abend) and raises a no-progress watchdog timeout.

Parameters:
- WP_W, 640: waypoint bus width in bits (80 ASCII chars).
- DEPTH, 8: log FIFO depth in records; power of two, at least 2.
- WDOG_CYCLES, 0: cycles without a waypoint change before timeout; 0 disables the watchdog.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- waypoint, in, WP_W: DUT waypoint bus.
- pc, in, 32: DUT thread-0 PC export.
- abend_syndrome, in, 8: 8'hFF while running; any other value means finished, and the value is the exit code.
- log_valid, out, 1: FIFO head record valid.
- log_ready, in, 1: consumer accepts the head record.
- log_cycle, out, 32: cycle stamp of the head record.
- log_delta, out, 32: cycles since the previous change.
- log_pc, out, 32: PC at the change.
- log_waypoint, out, WP_W: new waypoint value.
- cycle_count, out, 32: live run cycle counter.
- done, out, 1: abend latched.
- abend_code, out, 8: latched syndrome.
- timeout, out, 1: watchdog fired.
- drop_count, out, 16: records lost because the FIFO was full.

Behaviour:
- Reset: log_valid=0, FIFO empty, cycle_count=0, done=0, abend_code=8'hFF, timeout=0, drop_count=0, prev_wp=0, last_change=0, wdog=0, state=RUN.
  - The log_* data outputs are don't-care while log_valid=0.
- States:
  - RUN -> DONE when abend_syndrome != 8'hFF is sampled; abend_code latched that edge, done=1.
  - RUN -> TIMEOUT when WDOG_CYCLES != 0 and wdog reaches WDOG_CYCLES-1 with no change this cycle; timeout=1.
  - DONE and TIMEOUT are sticky until reset.
  - If abend and watchdog expiry coincide, DONE wins and timeout stays 0.
- cycle_count: increments by 1 each edge in RUN, saturates at 32'hFFFF_FFFF, frozen in DONE/TIMEOUT.
- Change detection, RUN only, evaluated each edge:
  - chg = (waypoint != prev_wp).
  - On chg: prev_wp <= waypoint, last_change <= cycle_count, wdog <= 0.
  - On chg with waypoint != 0: push the record {cycle_count, cycle_count - last_change (mod 2^32), pc, waypoint}.
  - Changes to zero update prev_wp and last_change but push nothing.
  - No chg: wdog increments, saturating.
- The change seen on the same edge as the abend is still logged; changes after entering DONE/TIMEOUT are ignored.
- FIFO is first-word-fall-through:
  - A record pushed at edge k appears on log_valid/log_* after edge k (1-cycle latency) when the FIFO was empty.
  - Pop happens on an edge where log_valid && log_ready.
  - Push into a full FIFO is accepted only if a pop occurs on the same edge; otherwise the record is dropped and drop_count increments, saturating at 16'hFFFF.
  - Push and pop on the same edge with the FIFO empty is impossible (log_valid=0).
  - Pointers wrap modulo DEPTH; occupancy is tracked with a DEPTH+1-state counter.
- The FIFO keeps draining in DONE/TIMEOUT.
- log_* outputs are stable while log_valid && !log_ready.
- Reset mid-run or mid-drain discards all queued records the next cycle.

Test Plan:
- Reset, then waypoint="INIT" at cycle 3 and "RUN1" at cycle 10, log_ready=1 -> two records: cycle 3 / delta 3, then cycle 10 / delta 7; log_valid pulses one cycle each.
- Waypoint A -> 0 at cycle 5 -> "B" at cycle 9 -> one record for A, then "B" with delta 4; no record for the zero value.
- log_ready=0, DEPTH=8, 11 distinct nonzero changes -> drop_count=3, 8 records held; then log_ready=1 -> exactly the first 8 drain in order, with stable data while stalled.
- abend_syndrome=8'h00 at cycle 20, waypoint change on the same edge -> done=1, abend_code=8'h00, cycle_count frozen at 20, change still logged; later changes ignored.
- WDOG_CYCLES=16, no change after cycle 4 -> timeout=1 after edge 20, cycle_count frozen; with abend on that same edge instead -> done=1, timeout=0.
- Reset asserted with 5 records queued -> log_valid=0, drop_count=0 and cycle_count=0 the next cycle.

Source files
------------

// File: rtl/kiwi_waypoint_logger.sv
// Waypoint monitor: timestamps waypoint changes, queues them in a FWFT FIFO,
// latches abend completion and raises a no-progress watchdog timeout.
module kiwi_waypoint_logger #(
  parameter int WP_W        = 640,
  parameter int DEPTH       = 8,
  parameter int WDOG_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WP_W-1:0] waypoint,
  input  logic [31:0]     pc,
  input  logic [7:0]      abend_syndrome,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [31:0]     log_cycle,
  output logic [31:0]     log_delta,
  output logic [31:0]     log_pc,
  output logic [WP_W-1:0] log_waypoint,
  output logic [31:0]     cycle_count,
  output logic            done,
  output logic [7:0]      abend_code,
  output logic            timeout,
  output logic [15:0]     drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = 96 + WP_W;

  typedef enum logic [1:0] {
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  state_t state, state_nx;

  logic [WP_W-1:0] prev_wp;
  logic [31:0]     last_change;
  logic [31:0]     wdog;

  logic run, chg, push, abend, expire;
  logic pop, full, wr_en, drop;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    run      = (state == RUN);
    chg      = 1'b0;
    push     = 1'b0;
    abend    = 1'b0;
    expire   = 1'b0;
    if (run) begin
      chg    = (waypoint != prev_wp);
      push   = chg && (waypoint != '0);
      abend  = (abend_syndrome != 8'hFF);
      expire = (WDOG_CYCLES != 0) && !chg &&
               (wdog == 32'(WDOG_CYCLES - 1));
      // Abend has priority over a coincident watchdog expiry
      if (abend)       state_nx = DONE;
      else if (expire) state_nx = TIMEOUT;
    end
  end

  assign pop   = log_valid && log_ready;
  assign full  = (count == CW'(DEPTH));
  assign wr_en = push && (!full || pop);
  assign drop  = push && !wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      abend_code  <= 8'hFF;
      drop_count  <= '0;
      prev_wp     <= '0;
      last_change <= '0;
      wdog        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // The count freezes on the edge that leaves RUN
      if (state_nx == RUN && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (abend)
        abend_code <= abend_syndrome;
      if (chg) begin
        prev_wp     <= waypoint;
        last_change <= cycle_count;
        wdog        <= '0;
      end else if (run && wdog != '1) begin
        wdog <= wdog + 32'd1;
      end
      if (drop && drop_count != '1)
        drop_count <= drop_count + 16'd1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {cycle_count, cycle_count - last_change, pc, waypoint};
  end

  assign {log_cycle, log_delta, log_pc, log_waypoint} = mem[rd_ptr];
  assign log_valid = (count != '0);
  assign done      = (state == DONE);
  assign timeout   = (state == TIMEOUT);

endmodule
